// File: rtl/regfile_pkg.sv
// Shared constants and state encoding for the register file and its clear sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package regfile_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_DEPTH = 16;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_t;

endpackage

// File: rtl/regfile_clear_fsm.sv
// Clear sequencer: on a clear request, walks every entry address once, one per cycle.
// Latency: busy rises one edge after clr_req is sampled and stays high for DEPTH cycles.
// Backpressure: clr_req is ignored while busy; a request held past the sweep starts another.
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter  int DEPTH = DEFAULT_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_req,
    output logic          busy,
    output logic          clr_en,
    output logic [AW-1:0] clr_addr
);

    clr_state_t    r_state;
    clr_state_t    w_state_nxt;
    logic [AW-1:0] r_cnt;
    logic [AW-1:0] w_cnt_nxt;

    // State and sweep counter registers; reset aborts any sweep in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic and per-cycle clear strobe for the entry addressed by the counter.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        clr_en      = 1'b0;
        clr_addr    = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (clr_req) begin
                    w_state_nxt = ST_CLEAR;
                    w_cnt_nxt   = '0;
                end
            end
            ST_CLEAR: begin
                clr_en    = 1'b1;
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == AW'(DEPTH - 1)) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
        endcase
    end

    // busy comes straight from the state flop, so it is glitch-free.
    assign busy = (r_state == ST_CLEAR);

endmodule

// File: rtl/regfile.sv
// Two-read / one-write register file with byte-lane writes, write-to-read bypass, optional zero entry.
// Latency: reads are combinational; writes land on the rising edge; bypass shows them the same cycle.
// Backpressure: while a clear sweep runs (busy), writes and clear requests are dropped.
module regfile
    import regfile_pkg::*;
#(
    parameter  int WIDTH    = DEFAULT_WIDTH,
    parameter  int DEPTH    = DEFAULT_DEPTH,
    parameter  bit ZERO_REG = 1'b1,
    localparam int AW       = $clog2(DEPTH),
    localparam int NB       = WIDTH / 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [NB-1:0]    wbe,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_b,
    input  logic             clr_req,
    output logic             busy
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] w_merged;
    logic             w_wr_ok;
    logic             w_clr_en;
    logic [AW-1:0]    w_clr_addr;

    // An address is usable if it names a real entry and is not the hardwired zero entry.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return ({1'b0, a} < (AW+1)'(DEPTH)) && !(ZERO_REG && (a == '0));
    endfunction

    regfile_clear_fsm #(
        .DEPTH (DEPTH)
    ) u_clear_fsm (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_req  (clr_req),
        .busy     (busy),
        .clr_en   (w_clr_en),
        .clr_addr (w_clr_addr)
    );

    assign w_wr_ok = we && !busy && addr_ok(waddr);

    // Word that the write would produce: enabled lanes from wdata, others from the stored entry.
    always_comb begin
        w_merged = r_mem[waddr];
        for (int b = 0; b < NB; b++) begin
            if (wbe[b]) begin
                w_merged[b*8 +: 8] = wdata[b*8 +: 8];
            end
        end
    end

    // Storage update: sweep clears take the entry; otherwise an accepted write stores the merged word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int e = 0; e < DEPTH; e++) begin
                r_mem[e] <= '0;
            end
        end else if (w_clr_en) begin
            r_mem[w_clr_addr] <= '0;
        end else if (w_wr_ok) begin
            r_mem[waddr] <= w_merged;
        end
    end

    // Port A read: zero for unusable addresses, bypass on a same-cycle write hit.
    always_comb begin
        rdata_a = '0;
        if (addr_ok(raddr_a)) begin
            rdata_a = (w_wr_ok && (raddr_a == waddr)) ? w_merged : r_mem[raddr_a];
        end
    end

    // Port B read: same rules as port A, fully independent.
    always_comb begin
        rdata_b = '0;
        if (addr_ok(raddr_b)) begin
            rdata_b = (w_wr_ok && (raddr_b == waddr)) ? w_merged : r_mem[raddr_b];
        end
    end

endmodule

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 The block SHALL take parameter WIDTH, default 32, meaning data width in bits; legal values are multiples of 8.
REQ-002 The block SHALL take parameter DEPTH, default 16, meaning number of entries, with DEPTH >= 2.
REQ-003 The block SHALL take parameter ZERO_REG, default 1, meaning entry 0 is hardwired to zero when 1.
REQ-004 Address width AW SHALL be $clog2(DEPTH), and byte-lane count NB SHALL be WIDTH/8.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-006 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port we, input, 1 bit: write enable.
REQ-008 The block SHALL have port waddr, input, AW bits: write address.
REQ-009 The block SHALL have port wdata, input, WIDTH bits: write data.
REQ-010 The block SHALL have port wbe, input, NB bits: byte-lane write enables.
REQ-011 The block SHALL have port raddr_a, input, AW bits: read address for port A.
REQ-012 The block SHALL have port rdata_a, output, WIDTH bits: read data for port A.
REQ-013 The block SHALL have port raddr_b, input, AW bits: read address for port B.
REQ-014 The block SHALL have port rdata_b, output, WIDTH bits: read data for port B.
REQ-015 The block SHALL have port clr_req, input, 1 bit: request to clear all entries.
REQ-016 The block SHALL have port busy, output, 1 bit: clear sweep in progress.

Function
REQ-017 A write SHALL occur on a rising clk edge when we=1 and busy=0: for each lane i with wbe[i]=1, entry[waddr] byte i takes wdata byte i; lanes with wbe[i]=0 hold their value.
REQ-018 Writes with waddr >= DEPTH, or with waddr=0 when ZERO_REG=1, SHALL be discarded without side effects.
REQ-019 Reads SHALL be combinational (zero latency) on both ports, independently.
REQ-020 Reads with raddr >= DEPTH, or with raddr=0 when ZERO_REG=1, SHALL return 0.
REQ-021 Bypass: when we=1, busy=0, and raddr equals a valid, writable waddr, rdata SHALL return the merged word (wbe lanes from wdata, other lanes from the stored entry); this applies to each port independently, including both ports at once.
REQ-022 The clear FSM SHALL have two states, IDLE and CLEAR, with a counter cnt of AW bits.
REQ-023 In IDLE, clr_req=1 at a rising edge SHALL move the FSM to CLEAR with cnt=0; busy is registered and reads 1 exactly while the FSM is in CLEAR.
REQ-024 In CLEAR, each rising edge SHALL zero entry[cnt] and increment cnt; the edge that clears entry DEPTH-1 SHALL return the FSM to IDLE, so busy is high for exactly DEPTH cycles.
REQ-025 While busy=1: writes and clr_req SHALL be ignored, bypass SHALL be disabled, and reads SHALL return current stored contents, which may be partially cleared.
REQ-026 When we=1 and clr_req=1 together in IDLE, the write SHALL complete on that edge and the sweep SHALL start; the entry is then zeroed during the sweep.
REQ-027 Any clr_req pulse width of 1 or more cycles SHALL start exactly one sweep; clr_req still high when the sweep ends SHALL start a new sweep.

Reset
REQ-028 rst_n=0 SHALL asynchronously zero all entries, set the FSM to IDLE, set cnt=0 and set busy=0; rdata_a and rdata_b then read 0.
REQ-029 Reset asserted mid-sweep SHALL abort the sweep immediately, with the same result as REQ-028.
REQ-030 After rst_n deasserts, the first rising edge SHALL accept writes and clr_req normally.

Structure
REQ-031 Package regfile_pkg SHALL hold the FSM state encoding (IDLE=0, CLEAR=1) and the default WIDTH and DEPTH constants.
REQ-032 The clear FSM and counter SHALL be a sub-module regfile_clear_fsm (ports clk, rst_n, clr_req, busy, clr_en, clr_addr); storage, write and bypass logic stay in regfile.

Verification
REQ-033 Scenario: reset, then write 0xDEADBEEF to entry 3 with wbe=1111 -> rdata_a reads 0xDEADBEEF at raddr_a=3 on the next cycle, and on the write cycle via bypass.
REQ-034 Scenario: entry 5 holds 0x11223344, write 0xAABBCCDD with wbe=0101 -> entry 5 = 0x11BB33DD, and the bypass value matches during the write cycle.
REQ-035 Scenario: write 0xFFFFFFFF to entry 0 with ZERO_REG=1 -> both ports read 0 at address 0; with ZERO_REG=0 they read 0xFFFFFFFF.
REQ-036 Scenario: fill entries 1..15, pulse clr_req for 1 cycle -> busy high for exactly 16 cycles, a write issued during busy is ignored, and all entries read 0 afterwards.
REQ-037 Scenario: assert rst_n=0 at cnt=7 of a sweep -> busy=0 and all entries 0 immediately, and a write on the first post-reset edge succeeds.
REQ-038 Scenario: we=1 and clr_req=1 in the same cycle on entry 9 -> after the sweep, entry 9 = 0 and busy has lasted DEPTH cycles.
